// File: rtl/jtpinpon_charrom_slot_if.sv
// Char ROM slot bus: layer fetch side plus SDRAM controller side.
// slave = ROM slot responder, master = layer/controller environment.
interface jtpinpon_charrom_slot_if #(
  parameter int AW  = 12,
  parameter int SDW = 22
);
  logic          slot_cs;
  logic [AW-1:0] slot_addr;
  logic [15:0]   slot_data;
  logic          slot_ok;

  logic [SDW-1:0] sdram_addr;
  logic           sdram_req;
  logic           sdram_ack;
  logic           sdram_dst;
  logic [15:0]    sdram_din;

  modport slave (
    input  slot_cs, slot_addr,
    output slot_data, slot_ok,
    output sdram_addr, sdram_req,
    input  sdram_ack, sdram_dst, sdram_din
  );

  modport master (
    output slot_cs, slot_addr,
    input  slot_data, slot_ok,
    input  sdram_addr, sdram_req,
    output sdram_ack, sdram_dst, sdram_din
  );
endinterface

// File: rtl/jtpinpon_charrom_slot.sv
// Char ROM slot: one-word SDRAM fetch with a small tag cache.
// Define JTPINPON_CHARROM_CACHE2_EN for a two-entry LRU cache.
module jtpinpon_charrom_slot #(
  parameter int             AW     = 12,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
) (
  input  logic clk,
  input  logic rst_n,
  jtpinpon_charrom_slot_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  req_addr_q;
  logic [SDW-1:0] addr_q;
  logic           hit;
  logic           launch;
  logic           fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = REQ;
      REQ: begin
        if (bus.sdram_ack)
          state_d = bus.sdram_dst ? IDLE : DATA;
      end
      DATA: if (bus.sdram_dst) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack+dst together in REQ fills straight away
  always_comb begin
    launch = (state_q == IDLE) && bus.slot_cs && !hit;
    fill   = bus.sdram_dst &&
             ((state_q == DATA) ||
              ((state_q == REQ) && bus.sdram_ack));
    bus.sdram_req  = (state_q == REQ);
    bus.sdram_addr = addr_q;
    bus.slot_ok    = hit && (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= '0;
      addr_q     <= '0;
    end else if (launch) begin
      req_addr_q <= bus.slot_addr;
      addr_q     <= OFFSET + SDW'(bus.slot_addr);
    end
  end

`ifdef JTPINPON_CHARROM_CACHE2_EN
  logic [1:0][AW-1:0] tag_q;
  logic [1:0][15:0]   data_q;
  logic [1:0]         valid_q;
  logic               lru_q;
  logic               hit0, hit1;

  always_comb begin
    hit0 = valid_q[0] && (tag_q[0] == bus.slot_addr);
    hit1 = valid_q[1] && (tag_q[1] == bus.slot_addr);
    hit  = hit0 || hit1;
    bus.slot_data = hit1 ? data_q[1] : data_q[0];
  end

  // lru_q names the entry the next fill replaces
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      lru_q   <= 1'b0;
    end else if (fill) begin
      tag_q[lru_q]   <= req_addr_q;
      data_q[lru_q]  <= bus.sdram_din;
      valid_q[lru_q] <= 1'b1;
      lru_q          <= ~lru_q;
    end else if (bus.slot_ok && bus.slot_cs) begin
      lru_q <= hit0;
    end
  end
`else
  logic [AW-1:0] tag_q;
  logic [15:0]   data_q;
  logic          valid_q;

  always_comb begin
    hit = valid_q && (tag_q == bus.slot_addr);
    bus.slot_data = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (fill) begin
      tag_q   <= req_addr_q;
      data_q  <= bus.sdram_din;
      valid_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_jtpinpon_charrom_slot.sv
// Directed bench for the char ROM slot.
// Inputs driven and outputs sampled on the falling edge.
module tb_jtpinpon_charrom_slot;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   req_cnt = 0;
  logic req_last = 1'b0;

  always #5 clk = ~clk;

  jtpinpon_charrom_slot_if #(.AW(12), .SDW(22)) bus ();

  jtpinpon_charrom_slot #(
    .AW(12), .SDW(22), .OFFSET(22'h10000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // counts rising edges of sdram_req
  always @(posedge clk) begin
    if (bus.sdram_req && !req_last) req_cnt <= req_cnt + 1;
    req_last <= bus.sdram_req;
  end

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sdram_req) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    bus.slot_cs   = 1'b0;
    bus.slot_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.sdram_dst = 1'b0;
    bus.sdram_din = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // full fetch: request, ack next cycle, dst one cycle later
  task automatic do_fetch(input logic [11:0] a, input logic [15:0] d);
    bit seen;
    bus.slot_cs   = 1'b1;
    bus.slot_addr = a;
    wait_req(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fetch_req addr=%h: no sdram_req seen", a);
    end
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.sdram_dst = 1'b1;
    bus.sdram_din = d;
    @(negedge clk);
    bus.sdram_dst = 1'b0;
  endtask

  task automatic test_reset();
    bus.slot_cs   = 1'b0;
    bus.slot_addr = 12'h000;
    bus.sdram_ack = 1'b0;
    bus.sdram_dst = 1'b0;
    bus.sdram_din = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.slot_ok !== 1'b0 || bus.sdram_req !== 1'b0 ||
        bus.slot_data !== 16'h0 || bus.sdram_addr !== 22'h0) begin
      errors++;
      $display("FAIL reset ok=%b req=%b data=%h addr=%h want 0", bus.slot_ok,
               bus.sdram_req, bus.slot_data, bus.sdram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_fill();
    bit seen;
    int c0;
    c0 = req_cnt;
    bus.slot_cs   = 1'b1;
    bus.slot_addr = 12'h123;
    wait_req(seen);
    checks++;
    if (!seen || bus.sdram_addr !== 22'h10123 || bus.slot_ok !== 1'b0) begin
      errors++;
      $display("FAIL first_req seen=%b addr=%h ok=%b want addr 10123 ok 0",
               seen, bus.sdram_addr, bus.slot_ok);
    end
    @(negedge clk);
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h10123) begin
      errors++;
      $display("FAIL req_hold req=%b addr=%h want 1 10123",
               bus.sdram_req, bus.sdram_addr);
    end
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    checks++;
    if (bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL req_drop req=%b want 0", bus.sdram_req);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.slot_ok !== 1'b0) begin
      errors++;
      $display("FAIL ok_in_data ok=%b want 0", bus.slot_ok);
    end
    bus.sdram_dst = 1'b1;
    bus.sdram_din = 16'hBEEF;
    @(negedge clk);
    bus.sdram_dst = 1'b0;
    bus.sdram_din = 16'h0000;
    checks++;
    if (bus.slot_ok !== 1'b1 || bus.slot_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL first_fill ok=%b data=%h want 1 beef",
               bus.slot_ok, bus.slot_data);
    end
    checks++;
    if (req_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL first_pulses got=%0d want 1", req_cnt - c0);
    end
  endtask

  task automatic test_hold();
    int bad_req = 0;
    int bad_ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sdram_req !== 1'b0) bad_req++;
      if (bus.slot_ok !== 1'b1) bad_ok++;
    end
    checks++;
    if (bad_req != 0 || bad_ok != 0) begin
      errors++;
      $display("FAIL hold bad_req=%0d bad_ok=%0d want 0 0", bad_req, bad_ok);
    end
  endtask

  task automatic test_addr_change();
    bit seen;
    bus.slot_addr = 12'h124;
    wait_req(seen);
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.slot_addr = 12'h125;
    @(negedge clk);
    checks++;
    if (bus.slot_ok !== 1'b0) begin
      errors++;
      $display("FAIL chg_data_ok ok=%b want 0", bus.slot_ok);
    end
    bus.sdram_dst = 1'b1;
    bus.sdram_din = 16'h1111;
    @(negedge clk);
    bus.sdram_dst = 1'b0;
    checks++;
    if (bus.slot_ok !== 1'b0 || bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL chg_after_fill ok=%b req=%b want 0 0",
               bus.slot_ok, bus.sdram_req);
    end
    @(negedge clk);
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h10125) begin
      errors++;
      $display("FAIL chg_second_req req=%b addr=%h want 1 10125",
               bus.sdram_req, bus.sdram_addr);
    end
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.sdram_dst = 1'b1;
    bus.sdram_din = 16'h2222;
    @(negedge clk);
    bus.sdram_dst = 1'b0;
    checks++;
    if (bus.slot_ok !== 1'b1 || bus.slot_data !== 16'h2222) begin
      errors++;
      $display("FAIL chg_second_fill ok=%b data=%h want 1 2222",
               bus.slot_ok, bus.slot_data);
    end
  endtask

  task automatic test_ack_dst_same();
    bit seen;
    bus.slot_addr = 12'h300;
    wait_req(seen);
    bus.sdram_ack = 1'b1;
    bus.sdram_dst = 1'b1;
    bus.sdram_din = 16'h5A5A;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.sdram_dst = 1'b0;
    checks++;
    if (bus.slot_ok !== 1'b1 || bus.slot_data !== 16'h5A5A ||
        bus.sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL ack_dst ok=%b data=%h req=%b want 1 5a5a 0",
               bus.slot_ok, bus.slot_data, bus.sdram_req);
    end
  endtask

  task automatic test_spurious_and_reset();
    bit seen;
    bus.sdram_dst = 1'b1;
    bus.sdram_din = 16'hFFFF;
    @(negedge clk);
    bus.sdram_dst = 1'b0;
    checks++;
    if (bus.slot_ok !== 1'b1 || bus.slot_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL spur_idle ok=%b data=%h want 1 5a5a",
               bus.slot_ok, bus.slot_data);
    end
    bus.slot_addr = 12'h301;
    wait_req(seen);
    bus.sdram_dst = 1'b1;
    @(negedge clk);
    bus.sdram_dst = 1'b0;
    checks++;
    if (bus.sdram_req !== 1'b1 || bus.slot_ok !== 1'b0) begin
      errors++;
      $display("FAIL spur_req req=%b ok=%b want 1 0",
               bus.sdram_req, bus.slot_ok);
    end
    bus.slot_addr = 12'h300;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sdram_req !== 1'b0 || bus.slot_ok !== 1'b0 ||
        bus.slot_data !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset req=%b ok=%b data=%h want 0 0 0",
               bus.sdram_req, bus.slot_ok, bus.slot_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef JTPINPON_CHARROM_CACHE2_EN
  task automatic test_cache2();
    int c0;
    int bad = 0;
    do_reset();
    c0 = req_cnt;
    do_fetch(12'h010, 16'hA010);
    do_fetch(12'h020, 16'hA020);
    for (int i = 0; i < 6; i++) begin
      bus.slot_addr = i[0] ? 12'h020 : 12'h010;
      #1;
      if (bus.slot_ok !== 1'b1 ||
          bus.slot_data !== (i[0] ? 16'hA020 : 16'hA010)) bad++;
      @(negedge clk);
    end
    bus.slot_addr = 12'h010;
    @(negedge clk);
    checks++;
    if (bad != 0 || req_cnt - c0 !== 2) begin
      errors++;
      $display("FAIL c2_alt bad=%0d reqs=%0d want 0 2", bad, req_cnt - c0);
    end
    do_fetch(12'h030, 16'hA030);
    bus.slot_addr = 12'h010;
    #1;
    checks++;
    if (bus.slot_ok !== 1'b1 || bus.slot_data !== 16'hA010) begin
      errors++;
      $display("FAIL c2_keep ok=%b data=%h want 1 a010",
               bus.slot_ok, bus.slot_data);
    end
    bus.slot_addr = 12'h020;
    #1;
    checks++;
    if (bus.slot_ok !== 1'b0) begin
      errors++;
      $display("FAIL c2_evict ok=%b want 0", bus.slot_ok);
    end
    bus.slot_cs = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_first_fill();
    test_hold();
    test_addr_change();
    test_ack_dst_same();
    test_spurious_and_reset();
`ifdef JTPINPON_CHARROM_CACHE2_EN
    test_cache2();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
